legv8_multicycle_sequencer: RTL

//  Multi-cycle control FSM for the LEGv8 datapath. Latches the 32-bit instruction from the instruction ROM and

---
 rtl/legv8_multicycle_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/legv8_multicycle_sequencer.sv
// Multi-cycle LEGv8 control sequencer: latches the instruction in FETCH, then walks
// EXEC and an optional MEM/BRANCH step, emitting a Moore-decoded 94-bit control word.
module legv8_multicycle_sequencer #(
  parameter int RETIRE_W        = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instruction,
  input  logic [4:0]          status,
  output logic [93:0]         control_word,
  output logic [63:0]         constant,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_BRANCH,
    S_HALT
  } state_t;

  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ORR   = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_EOR   = 5'b01100;
  localparam logic [4:0] FS_PASSB = 5'b11000;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REL  = 2'b11;

  function automatic logic signed [63:0] zext_imm12(input logic [11:0] imm);
    return {52'd0, imm};
  endfunction

  function automatic logic signed [63:0] sext_imm9(input logic [8:0] imm);
    return {{55{imm[8]}}, imm};
  endfunction

  function automatic logic signed [63:0] sext_imm19(input logic [18:0] imm);
    return {{45{imm[18]}}, imm};
  endfunction

  function automatic logic signed [63:0] sext_imm26(input logic [25:0] imm);
    return {{38{imm[25]}}, imm};
  endfunction

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic        retire;

  logic [10:0] opc;
  logic [4:0]  rd, rn, rm;
  logic        is_r, is_imm, is_ldur, is_stur, is_b, is_cb;
  logic [4:0]  alu_fs;
  logic        cb_taken;

  logic [4:0]         da, sa, sb, fs;
  logic [1:0]         ps;
  logic               wr, wm, sl, bsel, en_alu, en_mem;
  logic signed [63:0] k;

  // Only the registered Z flag steers branches; the other status bits are unused here.
  logic unused_status;
  assign unused_status = ^{status[4:2], status[0]};

  assign opc = ir[31:21];
  assign rd  = ir[4:0];
  assign rn  = ir[9:5];
  assign rm  = ir[20:16];

  assign is_ldur  = (opc == 11'h7C2);
  assign is_stur  = (opc == 11'h7C0);
  assign is_b     = (ir[31:26] == 6'b000101);
  assign is_cb    = (ir[31:25] == 7'b1011010);
  // IR[24] separates CBNZ (1) from CBZ (0).
  assign cb_taken = ir[24] ? ~status[1] : status[1];

  always_comb begin
    is_r   = 1'b0;
    is_imm = 1'b0;
    alu_fs = FS_ADD;
    case (opc)
      11'h458:          begin is_r   = 1'b1; alu_fs = FS_ADD; end
      11'h658:          begin is_r   = 1'b1; alu_fs = FS_SUB; end
      11'h450:          begin is_r   = 1'b1; alu_fs = FS_AND; end
      11'h550:          begin is_r   = 1'b1; alu_fs = FS_ORR; end
      11'h650:          begin is_r   = 1'b1; alu_fs = FS_EOR; end
      11'h488, 11'h489: begin is_imm = 1'b1; alu_fs = FS_ADD; end
      11'h688, 11'h689: begin is_imm = 1'b1; alu_fs = FS_SUB; end
      default:          ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    da        = 5'd0;
    sa        = 5'd0;
    sb        = 5'd0;
    fs        = 5'd0;
    ps        = PS_HOLD;
    wr        = 1'b0;
    wm        = 1'b0;
    sl        = 1'b0;
    bsel      = 1'b0;
    en_alu    = 1'b0;
    en_mem    = 1'b0;
    k         = '0;
    case (state)
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        if (is_r || is_imm) begin
          da     = rd;
          sa     = rn;
          sb     = rm;
          fs     = alu_fs;
          bsel   = is_imm;
          en_alu = 1'b1;
          wr     = 1'b1;
          ps     = PS_INC;
          k      = is_imm ? zext_imm12(ir[21:10]) : '0;
          retire = 1'b1;
        end else if (is_ldur) begin
          sa        = rn;
          bsel      = 1'b1;
          fs        = FS_ADD;
          k         = sext_imm9(ir[20:12]);
          state_nxt = S_MEM;
        end else if (is_stur) begin
          sa     = rn;
          sb     = rd;
          bsel   = 1'b1;
          fs     = FS_ADD;
          wm     = 1'b1;
          ps     = PS_INC;
          k      = sext_imm9(ir[20:12]);
          retire = 1'b1;
        end else if (is_b) begin
          ps     = PS_REL;
          k      = sext_imm26(ir[25:0]);
          retire = 1'b1;
        end else if (is_cb) begin
          sb        = rd;
          fs        = FS_PASSB;
          sl        = 1'b1;
          k         = sext_imm19(ir[23:5]);
          state_nxt = S_BRANCH;
        end else if (HALT_ON_ILLEGAL) begin
          state_nxt = S_HALT;
        end else begin
          ps     = PS_INC;
          retire = 1'b1;
        end
      end
      // Load writeback: address path repeated from EXEC with memory data steered to Rt.
      S_MEM: begin
        sa        = rn;
        bsel      = 1'b1;
        fs        = FS_ADD;
        k         = sext_imm9(ir[20:12]);
        en_mem    = 1'b1;
        wr        = 1'b1;
        da        = rd;
        ps        = PS_INC;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        k         = sext_imm19(ir[23:5]);
        ps        = cb_taken ? PS_REL : PS_INC;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_FETCH;
      ir            <= '0;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) ir <= instruction;
      if (retire) retired_count <= retired_count + RETIRE_W'(1);
    end
  end

  // EN_PC and PCsel are tied off for this instruction subset.
  assign control_word = {k, 1'b0, en_mem, en_alu, 1'b0, bsel, sl, wm, wr, ps, fs, sb, sa, da};
  assign constant     = k;
  assign halted       = (state == S_HALT);

endmodule
